// File: rtl/hazard_detection_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
// The master drives the hazard sources; the slave returns the stage enables and counters.
interface hazard_detection_unit_if;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_RegisterRt;
   logic [4:0]  IF_ID_RegisterRs;
   logic [4:0]  IF_ID_RegisterRt;
   logic        IF_ID_UsesRt;
   logic        branch_taken_EX;
   logic        EX_MEM_MemAccess;

   logic        PC_Write;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Write;
   logic        ID_EX_Bubble;
   logic        EX_MEM_Write;
   logic        MEM_WB_Bubble;
   logic        mem_busy;
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
             IF_ID_UsesRt, branch_taken_EX, EX_MEM_MemAccess,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
             EX_MEM_Write, MEM_WB_Bubble, mem_busy, stall_cycles, flush_count
   );

   modport slave (
      input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
             IF_ID_UsesRt, branch_taken_EX, EX_MEM_MemAccess,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
             EX_MEM_Write, MEM_WB_Bubble, mem_busy, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use bubbles, taken-branch
// flushes and a memory-wait FSM, plus saturating stall and flush counters.
module hazard_detection_unit #(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hazard_detection_unit_if.slave hdu
);

   // RUN already covers the first stall cycle, so the wait counter starts two short.
   localparam logic [3:0] WaitInit = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   state_e      stateQ, stateD;
   logic [3:0]  cntQ, cntD;
   logic [15:0] stallCntQ, flushCntQ;
   logic        memStall;
   logic        loadUse;

   logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemWrite, memWbBubble;
   logic memBusy;

   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      memStall = 1'b0;
      unique case (stateQ)
         StRun: begin
            if (hdu.EX_MEM_MemAccess && (MEM_LATENCY > 1)) begin
               memStall = 1'b1;
               stateD   = StMemWait;
               cntD     = WaitInit;
            end
         end
         StMemWait: begin
            // MemAccess is deliberately ignored here so one access cannot re-trigger.
            if (cntQ != 4'd0) begin
               memStall = 1'b1;
               cntD     = cntQ - 4'd1;
            end else begin
               stateD = StRun;
            end
         end
         default: stateD = StRun;
      endcase
   end

   always_comb begin
      loadUse = hdu.ID_EX_MemRead && (hdu.ID_EX_RegisterRt != 5'd0) &&
                ((hdu.ID_EX_RegisterRt == hdu.IF_ID_RegisterRs) ||
                 (hdu.IF_ID_UsesRt && (hdu.ID_EX_RegisterRt == hdu.IF_ID_RegisterRt)));
   end

   always_comb begin
      pcWrite     = 1'b1;
      ifIdWrite   = 1'b1;
      ifIdFlush   = 1'b0;
      idExWrite   = 1'b1;
      idExBubble  = 1'b0;
      exMemWrite  = 1'b1;
      memWbBubble = 1'b0;
      memBusy     = 1'b0;
      if (!rst_n) begin
         // hold defaults while reset is asserted
      end else if (memStall) begin
         pcWrite     = 1'b0;
         ifIdWrite   = 1'b0;
         idExWrite   = 1'b0;
         exMemWrite  = 1'b0;
         memWbBubble = 1'b1;
         memBusy     = 1'b1;
      end else if (hdu.branch_taken_EX) begin
         // Branch wins over load-use: the dependent ID instruction is squashed anyway.
         ifIdFlush  = 1'b1;
         idExBubble = 1'b1;
      end else if (loadUse) begin
         pcWrite    = 1'b0;
         ifIdWrite  = 1'b0;
         idExBubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ    <= StRun;
         cntQ      <= 4'd0;
         stallCntQ <= 16'd0;
         flushCntQ <= 16'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (!pcWrite && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
         end
         if (ifIdFlush && (flushCntQ != 16'hFFFF)) begin
            flushCntQ <= flushCntQ + 16'd1;
         end
      end
   end

   assign hdu.PC_Write      = pcWrite;
   assign hdu.IF_ID_Write   = ifIdWrite;
   assign hdu.IF_ID_Flush   = ifIdFlush;
   assign hdu.ID_EX_Write   = idExWrite;
   assign hdu.ID_EX_Bubble  = idExBubble;
   assign hdu.EX_MEM_Write  = exMemWrite;
   assign hdu.MEM_WB_Bubble = memWbBubble;
   assign hdu.mem_busy      = memBusy;
   assign hdu.stall_cycles  = stallCntQ;
   assign hdu.flush_count   = flushCntQ;

endmodule
